layer_sequencer: RTL

Control sequencer that sits directly upstream of the row index counter and generates the strobes it consumes: `new_row`, `new_vector`, `new_quadrant_row`, `quadrant_msb`. It walks a column index across each weight row, processes rows in pairs, and repeats each pair once per input vector. It covers three row pairs per quadrant and two quadrants per layer, which gives downstream row indices 0–5 and then 6–11. `done` pulses when the layer completes.

---
 rtl/layer_sequencer_if.sv | 25 ++
 rtl/layer_sequencer.sv | 105 ++++++++++
 2 files changed

// File: rtl/layer_sequencer_if.sv
// Handshake and strobe bundle between the layer sequencer and its neighbours.
// The driver (master) supplies start/en; the sequencer (slave) returns index, strobes and status.
interface layer_sequencer_if #(
  parameter int COL_W = 3
) ();
  logic             start;
  logic             en;
  logic [COL_W-1:0] col_index;
  logic             new_row;
  logic             new_vector;
  logic             new_quadrant_row;
  logic             quadrant_msb;
  logic             busy;
  logic             done;

  modport master (
    output start, en,
    input  col_index, new_row, new_vector, new_quadrant_row, quadrant_msb, busy, done
  );

  modport slave (
    input  start, en,
    output col_index, new_row, new_vector, new_quadrant_row, quadrant_msb, busy, done
  );
endinterface

// File: rtl/layer_sequencer.sv
// Walks columns across row pairs, repeats each pair per input vector, covers three pairs per
// quadrant and two quadrants per layer, and emits the strobes the row index counter consumes.
module layer_sequencer #(
  parameter int COLS        = 8,
  parameter int NUM_VECTORS = 4,
  parameter int COL_W       = 3
) (
  input  logic              clock,
  input  logic              clear,
  layer_sequencer_if.slave  bus
);
  localparam int VEC_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t           state_reg, state_next;
  logic [COL_W-1:0] col_reg, col_next;
  logic             rip_reg, rip_next;
  logic [VEC_W-1:0] vec_reg, vec_next;
  logic [1:0]       pair_reg, pair_next;
  logic             quad_reg, quad_next;

  logic col_last, vec_last, pair_last;
  logic row_end, pair_end, layer_quad_end;

  assign col_last  = (col_reg == COL_W'(COLS - 1));
  assign vec_last  = (vec_reg == VEC_W'(NUM_VECTORS - 1));
  assign pair_last = (pair_reg == 2'd2);

  always_ff @(posedge clock) begin
    if (clear) begin
      state_reg <= IDLE;
      col_reg   <= '0;
      rip_reg   <= 1'b0;
      vec_reg   <= '0;
      pair_reg  <= '0;
      quad_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      rip_reg   <= rip_next;
      vec_reg   <= vec_next;
      pair_reg  <= pair_next;
      quad_reg  <= quad_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    rip_next   = rip_reg;
    vec_next   = vec_reg;
    pair_next  = pair_reg;
    quad_next  = quad_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) state_next = RUN;
      end
      RUN: begin
        if (bus.en) begin
          if (!col_last) begin
            col_next = col_reg + COL_W'(1);
          end else begin
            col_next = '0;
            if (!rip_reg) begin
              rip_next = 1'b1;
            end else if (!vec_last) begin
              rip_next   = 1'b0;
              vec_next   = vec_reg + VEC_W'(1);
              state_next = GAP;
            end else begin
              rip_next = 1'b0;
              vec_next = '0;
              if (pair_last) begin
                // Quadrant complete; the second one also finishes the layer.
                pair_next = '0;
                quad_next = ~quad_reg;
                if (quad_reg) state_next = IDLE;
              end else begin
                pair_next = pair_reg + 2'd1;
              end
            end
          end
        end
      end
      GAP: begin
        if (bus.en) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  assign row_end        = (state_reg == RUN) && bus.en && col_last;
  assign pair_end       = row_end && rip_reg && vec_last;
  assign layer_quad_end = pair_end && pair_last;

  assign bus.col_index        = col_reg;
  assign bus.new_row          = row_end && !pair_end;
  assign bus.new_quadrant_row = pair_end;
  assign bus.new_vector       = pair_end || ((state_reg == GAP) && bus.en);
  // Shows the next quadrant during its closing strobe so the downstream clear loads the new base.
  assign bus.quadrant_msb     = quad_reg ^ layer_quad_end;
  assign bus.busy             = (state_reg != IDLE);
  assign bus.done             = layer_quad_end && quad_reg;
endmodule
